// File: rtl/barrel_pkg.sv
// Shared types for the pipelined barrel shifter.
package barrel_pkg;

    // Shift operation carried alongside each word through the pipeline.
    typedef enum logic [1:0] {
        ROR = 2'd0,
        ROL = 2'd1,
        LSR = 2'd2,
        ASR = 2'd3
    } shift_mode_e;

endpackage

// File: rtl/barrel_stage.sv
// One register stage of the barrel shifter: shifts the incoming word by STEP
// when the matching amount bit is set, then registers word and sideband.
module barrel_stage
    import barrel_pkg::*;
#(
    parameter int N    = 64,
    parameter int M    = $clog2(N),
    parameter int TW   = 4,
    parameter int STEP = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_adv,
    input  logic          i_valid,
    input  logic [N-1:0]  i_data,
    input  logic [M-1:0]  i_amt,
    input  shift_mode_e   i_mode,
    input  logic [TW-1:0] i_tag,
    output logic          o_ready,
    output logic          o_valid,
    output logic [N-1:0]  o_data,
    output logic [M-1:0]  o_amt,
    output shift_mode_e   o_mode,
    output logic [TW-1:0] o_tag
);

    // Amount bit that selects this stage's step.
    localparam int BIT = $clog2(STEP);

    // Fixed-distance shift; ASR replicates the current MSB, which is still the
    // original sign bit because earlier stages also filled with it.
    function automatic logic [N-1:0] shift_step(input logic [N-1:0] d, input shift_mode_e m);
        logic [N-1:0] r;
        case (m)
            ROR:     r = {d[STEP-1:0], d[N-1:STEP]};
            ROL:     r = {d[N-STEP-1:0], d[N-1:N-STEP]};
            LSR:     r = {{STEP{1'b0}}, d[N-1:STEP]};
            ASR:     r = {{STEP{d[N-1]}}, d[N-1:STEP]};
            default: r = d;
        endcase
        return r;
    endfunction

    logic          r_valid;
    logic [N-1:0]  r_data;
    logic [M-1:0]  r_amt;
    shift_mode_e   r_mode;
    logic [TW-1:0] r_tag;
    logic          w_load;
    logic [N-1:0]  w_shifted;

    // Load when empty or when the held word is moving on; apply this stage's step.
    always_comb begin
        w_load = !r_valid || i_adv;
        if (i_amt[BIT]) begin
            w_shifted = shift_step(i_data, i_mode);
        end else begin
            w_shifted = i_data;
        end
    end

    // Stage register; payload only updates for a real word so an emptied
    // stage keeps its last data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_amt   <= '0;
            r_mode  <= ROR;
            r_tag   <= '0;
        end else if (w_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_shifted;
                r_amt  <= i_amt;
                r_mode <= i_mode;
                r_tag  <= i_tag;
            end
        end
    end

    assign o_ready = w_load;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_amt   = r_amt;
    assign o_mode  = r_mode;
    assign o_tag   = r_tag;

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter (ROR/ROL/LSR/ASR) with valid/ready on both sides.
// Stage g shifts by 2^(M-1-g), largest step first; a tag rides with each word.
module barrel_shift_pipe
    import barrel_pkg::*;
#(
    parameter int N  = 64,
    parameter int M  = $clog2(N),
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [M-1:0]  in_amt,
    input  logic [1:0]    in_mode,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [TW-1:0] out_tag
);

    // Index 0 is the producer side; index g+1 is the output of stage g.
    logic [M:0]    w_valid;
    logic [N-1:0]  w_data [M+1];
    logic [M-1:0]  w_amt  [M+1];
    shift_mode_e   w_mode [M+1];
    logic [TW-1:0] w_tag  [M+1];
    logic [M-1:0]  w_adv;
    logic [M-1:0]  w_ready;

    assign w_valid[0] = in_valid;
    assign w_data[0]  = in_data;
    assign w_amt[0]   = in_amt;
    assign w_mode[0]  = shift_mode_e'(in_mode);
    assign w_tag[0]   = in_tag;

    genvar g;
    generate
        for (g = 0; g < M; g++) begin : g_stage
            barrel_stage #(
                .N    (N),
                .M    (M),
                .TW   (TW),
                .STEP (1 << (M - 1 - g))
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .i_adv   (w_adv[g]),
                .i_valid (w_valid[g]),
                .i_data  (w_data[g]),
                .i_amt   (w_amt[g]),
                .i_mode  (w_mode[g]),
                .i_tag   (w_tag[g]),
                .o_ready (w_ready[g]),
                .o_valid (w_valid[g+1]),
                .o_data  (w_data[g+1]),
                .o_amt   (w_amt[g+1]),
                .o_mode  (w_mode[g+1]),
                .o_tag   (w_tag[g+1])
            );

            // Advance chain: the last stage drains into the consumer, every
            // other stage drains into the next one whenever that one can load.
            if (g == M - 1) begin : g_last
                assign w_adv[g] = !w_valid[M] || out_ready;
            end else begin : g_mid
                assign w_adv[g] = w_ready[g+1];
            end
        end
    endgenerate

    assign in_ready  = w_ready[0];
    assign out_valid = w_valid[M];
    assign out_data  = w_data[M];
    assign out_tag   = w_tag[M];

endmodule
